// File: rtl/crc_serial_checker.sv
// Serial CRC checker for g(y) = y^9 + y^8 + y + 1: divides a MSB-first 19-bit codeword
// through a 9-bit LFSR and reports the recovered message, syndrome and pass flag per frame.
module crc_serial_checker #(
  parameter int unsigned       MSG_W = 10,
  parameter int unsigned       CRC_W = 9,
  parameter logic [CRC_W-1:0]  POLY  = 9'h103
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  input  logic             sof_i,
  output logic [MSG_W-1:0] msg_out_o,
  output logic [CRC_W-1:0] syndrome_out_o,
  output logic             crc_ok_o,
  output logic             frame_valid_o,
  output logic             aborted_o,
  output logic             busy_o
);

  localparam int unsigned FrameLen = MSG_W + CRC_W;
  localparam int unsigned CntW     = 5;

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CRC_W-1:0]  lfsr_q;
  logic [MSG_W-1:0]  msg_q;
  logic [MSG_W-1:0]  msg_out_q;
  logic [CRC_W-1:0]  syn_q;
  logic              ok_q;
  logic              fv_q;
  logic              ab_q;
  logic              busy_q;

  logic              start;
  logic              take;
  logic              last;
  logic              fb;
  logic [CntW-1:0]   cnt_base;
  logic [CRC_W-1:0]  lfsr_base;
  logic [CRC_W-1:0]  lfsr_step;
  logic [MSG_W-1:0]  msg_base;
  logic [MSG_W-1:0]  msg_step;

  // A qualified sof restarts the frame in any state, so the datapath steps from cleared bases.
  always_comb begin
    start     = bit_valid_i & sof_i;
    take      = bit_valid_i & (sof_i | (state_q == StRecv));
    cnt_base  = start ? '0 : cnt_q;
    lfsr_base = start ? '0 : lfsr_q;
    msg_base  = start ? '0 : msg_q;
    fb        = lfsr_base[CRC_W-1] ^ bit_in_i;
    lfsr_step = {lfsr_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    msg_step  = (cnt_base < CntW'(MSG_W)) ? {msg_base[MSG_W-2:0], bit_in_i} : msg_base;
    last      = take & (cnt_base == CntW'(FrameLen - 1));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      lfsr_q    <= '0;
      msg_q     <= '0;
      msg_out_q <= '0;
      syn_q     <= '0;
      ok_q      <= 1'b0;
      fv_q      <= 1'b0;
      ab_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      ab_q <= 1'b0;
      if (take) begin
        lfsr_q <= lfsr_step;
        msg_q  <= msg_step;
        cnt_q  <= cnt_base + 1'b1;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRecv;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRecv: begin
          if (start) begin
            ab_q <= 1'b1;
          end else if (last) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            msg_out_q <= msg_step;
            syn_q     <= lfsr_step;
            ok_q      <= (lfsr_step == '0);
            fv_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign msg_out_o      = msg_out_q;
  assign syndrome_out_o = syn_q;
  assign crc_ok_o       = ok_q;
  assign frame_valid_o  = fv_q;
  assign aborted_o      = ab_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_crc_serial_checker.sv
// Scoreboard bench for crc_serial_checker: the driver queues expected frame results and abort
// pulses, a forked monitor pops and compares whenever the DUT pulses frame_valid or aborted.
module tb_crc_serial_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       sof;
  logic [9:0] msg_out;
  logic [8:0] syndrome_out;
  logic       crc_ok;
  logic       frame_valid;
  logic       aborted;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [9:0] msg;
    logic [8:0] syn;
    logic       ok;
    int         cyc;
  } exp_t;

  exp_t fq[$];
  int   aq[$];
  exp_t e;
  int   a;

  localparam logic [18:0] Cw1 = 19'b1100000011_000000000;
  localparam logic [18:0] Cw2 = 19'b0000000001_100000011;
  localparam logic [18:0] Cw3 = 19'b0000000001_100000010;

  crc_serial_checker #(
    .MSG_W (10),
    .CRC_W (9),
    .POLY  (9'h103)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .bit_in_i       (bit_in),
    .bit_valid_i    (bit_valid),
    .sof_i          (sof),
    .msg_out_o      (msg_out),
    .syndrome_out_o (syndrome_out),
    .crc_ok_o       (crc_ok),
    .frame_valid_o  (frame_valid),
    .aborted_o      (aborted),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b, input logic s);
    bit_in    = b;
    sof       = s;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of cw; a full frame queues its hand-computed result.
  task automatic send_cw(input logic [18:0] cw, input int nbits, input int gap,
                         input logic [9:0] msg, input logic [8:0] syn, input logic ok);
    exp_t x;
    for (int i = 0; i < nbits; i++) begin
      if (i == 18) begin
        x.msg = msg;
        x.syn = syn;
        x.ok  = ok;
        x.cyc = cyc + 1;
        fq.push_back(x);
      end
      drive_bit(cw[18-i], i == 0);
      if (i == 5) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
      repeat (gap) idle_cycle();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_msg"}, {22'd0, msg_out}, 32'd0);
    chk({tag, "_syn"}, {23'd0, syndrome_out}, 32'd0);
    chk({tag, "_ok"}, {31'd0, crc_ok}, 32'd0);
    chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_ab"}, {31'd0, aborted}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    sof       = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (frame_valid) begin
            if (fq.size() == 0) begin
              chk("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
              e = fq.pop_front();
              chk("msg_out", {22'd0, msg_out}, {22'd0, e.msg});
              chk("syndrome_out", {23'd0, syndrome_out}, {23'd0, e.syn});
              chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
              chk("frame_valid_cycle", cyc, e.cyc);
              chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
          end
          if (aborted) begin
            if (aq.size() == 0) begin
              chk("unexpected_aborted", 32'd1, 32'd0);
            end else begin
              a = aq.pop_front();
              chk("aborted_cycle", cyc, a);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;
    idle_cycle();

    // sof without bit_valid and stray valid bits in IDLE are both ignored
    sof = 1'b1;
    idle_cycle();
    sof = 1'b0;
    chk("sof_no_valid_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      idle_cycle();
    end
    bit_valid = 1'b0;
    chk("valid_no_sof_idle", {31'd0, busy}, 32'd0);

    send_cw(Cw1, 19, 0, 10'b1100000011, 9'b000000000, 1'b1);
    repeat (3) idle_cycle();

    send_cw(Cw2, 19, 1, 10'b0000000001, 9'b000000000, 1'b1);
    repeat (3) idle_cycle();

    send_cw(Cw3, 19, 0, 10'b0000000001, 9'b100000011, 1'b0);
    repeat (3) idle_cycle();

    // Restarting sof at bit 7 of a partial frame
    send_cw(Cw1, 7, 0, 10'd0, 9'd0, 1'b0);
    aq.push_back(cyc + 1);
    send_cw(Cw2, 19, 0, 10'b0000000001, 9'b000000000, 1'b1);
    repeat (3) idle_cycle();

    // Back-to-back frames, no gap
    send_cw(Cw1, 19, 0, 10'b1100000011, 9'b000000000, 1'b1);
    send_cw(Cw2, 19, 0, 10'b0000000001, 9'b000000000, 1'b1);
    idle_cycle();
    chk("busy_after_b2b", {31'd0, busy}, 32'd0);
    repeat (2) idle_cycle();

    // Reset mid-frame at bit 12
    send_cw(Cw3, 12, 0, 10'd0, 9'd0, 1'b0);
    reset = 1'b1;
    idle_cycle();
    chk_zero_outputs("midreset");
    reset = 1'b0;
    idle_cycle();
    send_cw(Cw3, 19, 0, 10'b0000000001, 9'b100000011, 1'b0);

    repeat (5) idle_cycle();
    chk("missing_frame_valid", fq.size(), 32'd0);
    chk("missing_aborted", aq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
